// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem -- word-organised data memory with word / half / byte access.
//
// Loads are purely combinational from the array contents (RD follows Addr and
// MemDataType in the same cycle). Stores commit on the rising edge of clk when
// the access is aligned and of a supported size. Sub-word stores merge into
// the existing word so the untouched byte lanes keep their contents.
//
// Optional feature macro: DATA_MEM_BYTE_OPS_EN
//   defined   -> MemDataType 3'b010 performs byte loads and byte stores
//   undefined -> 3'b010 is an unsupported size: stores are dropped and
//                loads return the full word
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (a power of two, so the index wraps)
//   ADDR_BASE    byte address that maps onto word 0
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous active-high reset; clears array, count and flag
//   PC           address of the issuing instruction (store log only)
//   Addr         byte address of the access
//   WD           store data, right-aligned
//   MemWrite     store request for the current cycle
//   MemDataType  3'b000 word, 3'b001 half, 3'b010 byte
//   RD           load data, sign-extended to 32 bits
//   AlignErr     sticky flag, set by a misaligned store until reset
//   WriteCount   number of committed stores (wraps at 2^32)
// -----------------------------------------------------------------------------
module data_mem #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic        MemWrite,
    input  logic [2:0]  MemDataType,
    output logic [31:0] RD,
    output logic        AlignErr,
    output logic [31:0] WriteCount
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [2:0] TYPE_WORD = 3'b000;
    localparam logic [2:0] TYPE_HALF = 3'b001;
`ifdef DATA_MEM_BYTE_OPS_EN
    localparam logic [2:0] TYPE_BYTE = 3'b010;
`endif

    logic [31:0]   mem [DEPTH_WORDS];

    logic [IW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [15:0]   rd_half;
    logic [7:0]    rd_byte;
    logic [31:0]   merged_word;
    logic          type_ok;
    logic          misaligned;
    logic          do_commit;
    logic          do_align_err;

    // Word index relative to ADDR_BASE; truncating to IW bits drops the upper
    // address bits, which is what makes out-of-range addresses wrap.
    assign word_idx = IW'((Addr - ADDR_BASE) >> 2);
    assign rd_word  = mem[word_idx];

    // Decode the access size, its alignment, and the word that a store would
    // leave behind. The merged word starts from the current contents so only
    // the addressed lanes are replaced.
    always_comb begin
        type_ok     = 1'b0;
        misaligned  = 1'b0;
        merged_word = rd_word;
        case (MemDataType)
            TYPE_WORD: begin
                type_ok     = 1'b1;
                misaligned  = (Addr[1:0] != 2'b00);
                merged_word = WD;
            end
            TYPE_HALF: begin
                type_ok    = 1'b1;
                misaligned = Addr[0];
                if (Addr[1]) begin
                    merged_word[31:16] = WD[15:0];
                end else begin
                    merged_word[15:0] = WD[15:0];
                end
            end
`ifdef DATA_MEM_BYTE_OPS_EN
            TYPE_BYTE: begin
                type_ok = 1'b1;
                merged_word[{Addr[1:0], 3'b000} +: 8] = WD[7:0];
            end
`endif
            default: begin
                type_ok = 1'b0;
            end
        endcase
    end

    // Unsupported sizes neither commit nor raise the alignment flag.
    assign do_commit    = MemWrite && type_ok && !misaligned;
    assign do_align_err = MemWrite && type_ok && misaligned;

    // Load path. A misaligned load simply uses the lane its low address bits
    // select; anything that is not a recognised sub-word size returns the word.
    always_comb begin
        rd_half = Addr[1] ? rd_word[31:16] : rd_word[15:0];
        rd_byte = rd_word[{Addr[1:0], 3'b000} +: 8];
        RD      = rd_word;
        case (MemDataType)
            TYPE_HALF: RD = {{16{rd_half[15]}}, rd_half};
`ifdef DATA_MEM_BYTE_OPS_EN
            TYPE_BYTE: RD = {{24{rd_byte[7]}}, rd_byte};
`endif
            default:   RD = rd_word;
        endcase
    end

    // State update. Reset wins over any store presented in the same cycle and
    // clears every word at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
            WriteCount <= '0;
            AlignErr   <= 1'b0;
        end else begin
            if (do_commit) begin
                mem[word_idx] <= merged_word;
                WriteCount    <= WriteCount + 32'd1;
`ifndef SYNTHESIS
                $display("%d@%h: *%h <= %h", $time, PC, {Addr[31:2], 2'b00}, merged_word);
`endif
            end
            if (do_align_err) begin
                AlignErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// -----------------------------------------------------------------------------
// tb_data_mem -- self-checking bench for data_mem.
//
// A byte-addressed reference model (a flat byte array, little-endian) tracks
// what the memory should hold. A table of directed store/load pairs covers the
// documented scenarios with hand-computed constants, a few hand-written
// sequences cover sticky flag, same-cycle read and reset priority, and a
// randomized phase compares RD / WriteCount / AlignErr against the model.
// Honours DATA_MEM_BYTE_OPS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_data_mem;

    localparam int          DEPTH    = 1024;
    localparam logic [31:0] BASE     = 32'h0000_0000;
    localparam int          MEMBYTES = DEPTH * 4;
`ifdef DATA_MEM_BYTE_OPS_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif
    localparam int CNT_B = BYTE_EN ? 1 : 0;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic        MemWrite;
    logic [2:0]  MemDataType;
    logic [31:0] RD;
    logic        AlignErr;
    logic [31:0] WriteCount;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  mb [MEMBYTES];
    logic [31:0] mCount;
    logic        mErr;

    data_mem #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (PC),
        .Addr       (Addr),
        .WD         (WD),
        .MemWrite   (MemWrite),
        .MemDataType(MemDataType),
        .RD         (RD),
        .AlignErr   (AlignErr),
        .WriteCount (WriteCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of bytes a store of this type touches; 0 means unsupported.
    function automatic int sizeOf(input logic [2:0] t);
        case (t)
            3'b000:  return 4;
            3'b001:  return 2;
            3'b010:  return BYTE_EN ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] t, input logic [31:0] a);
        logic [31:0] off;
        int          b;
        logic [15:0] h;
        logic [7:0]  by;
        off = (a - BASE) % MEMBYTES;
        if (t == 3'b001) begin
            b = int'(off) & ~1;
            h = {mb[b + 1], mb[b]};
            return {{16{h[15]}}, h};
        end else if (t == 3'b010 && BYTE_EN) begin
            by = mb[int'(off)];
            return {{24{by[7]}}, by};
        end else begin
            b = int'(off) & ~3;
            return {mb[b + 3], mb[b + 2], mb[b + 1], mb[b]};
        end
    endfunction

    task automatic modelStep();
        int          size;
        logic [31:0] off;
        if (reset) begin
            foreach (mb[i]) mb[i] = 8'h00;
            mCount = 32'd0;
            mErr   = 1'b0;
        end else if (MemWrite) begin
            size = sizeOf(MemDataType);
            if (size != 0) begin
                if ((Addr % 32'(size)) != 0) begin
                    mErr = 1'b1;
                end else begin
                    off = Addr - BASE;
                    for (int k = 0; k < size; k++) begin
                        mb[int'((off + 32'(k)) % MEMBYTES)] = WD[8*k +: 8];
                    end
                    mCount = mCount + 32'd1;
                end
            end
        end
    endtask

    // The model advances on every rising edge using the inputs the DUT sees.
    initial begin
        mCount = 32'd0;
        mErr   = 1'b0;
        foreach (mb[i]) mb[i] = 8'h00;
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Inputs change on the falling edge, well away from the active edge.
    task automatic applyStimulus(input logic r, input logic w, input logic [2:0] t,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] pc);
        @(negedge clk);
        reset       = r;
        MemWrite    = w;
        MemDataType = t;
        Addr        = a;
        WD          = d;
        PC          = pc;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  stType;
        logic [31:0] stAddr;
        logic [31:0] stData;
        logic [2:0]  ldType;
        logic [31:0] ldAddr;
        logic [31:0] expRd;
        logic [31:0] expCount;
        logic        expErr;
    } vec_t;

    vec_t vecs [12];

    initial begin
        reset       = 1'b1;
        MemWrite    = 1'b0;
        MemDataType = 3'b000;
        Addr        = 32'h0;
        WD          = 32'h0;
        PC          = 32'h0;

        // store / then-load pairs with hand-computed expectations
        vecs[0]  = '{1'b1, 3'b000, 32'h10,   32'h1234_5678, 3'b000, 32'h10, 32'h1234_5678, 32'd1, 1'b0};
        vecs[1]  = '{1'b1, 3'b000, 32'h20,   32'h8765_4321, 3'b000, 32'h20, 32'h8765_4321, 32'd2, 1'b0};
        vecs[2]  = '{1'b1, 3'b001, 32'h22,   32'h0000_BEEF, 3'b000, 32'h20, 32'hBEEF_4321, 32'd3, 1'b0};
        vecs[3]  = '{1'b0, 3'b000, 32'h0,    32'h0,         3'b001, 32'h22, 32'hFFFF_BEEF, 32'd3, 1'b0};
        vecs[4]  = '{1'b0, 3'b000, 32'h0,    32'h0,         3'b001, 32'h20, 32'h0000_4321, 32'd3, 1'b0};
`ifdef DATA_MEM_BYTE_OPS_EN
        vecs[5]  = '{1'b1, 3'b010, 32'h33,   32'h0000_0080, 3'b000, 32'h30, 32'h8000_0000, 32'd4, 1'b0};
        vecs[6]  = '{1'b0, 3'b000, 32'h0,    32'h0,         3'b010, 32'h33, 32'hFFFF_FF80, 32'd4, 1'b0};
`else
        vecs[5]  = '{1'b1, 3'b010, 32'h33,   32'h0000_0080, 3'b000, 32'h30, 32'h0000_0000, 32'd3, 1'b0};
        vecs[6]  = '{1'b0, 3'b000, 32'h0,    32'h0,         3'b010, 32'h33, 32'h0000_0000, 32'd3, 1'b0};
`endif
        vecs[7]  = '{1'b1, 3'b000, 32'h1000, 32'hAAAA_5555, 3'b000, 32'h0,  32'hAAAA_5555, 32'(4 + CNT_B), 1'b0};
        vecs[8]  = '{1'b1, 3'b111, 32'h10,   32'hDEAD_BEEF, 3'b000, 32'h10, 32'h1234_5678, 32'(4 + CNT_B), 1'b0};
        vecs[9]  = '{1'b0, 3'b000, 32'h0,    32'h0,         3'b000, 32'h13, 32'h1234_5678, 32'(4 + CNT_B), 1'b0};
        vecs[10] = '{1'b0, 3'b000, 32'h0,    32'h0,         3'b001, 32'h23, 32'hFFFF_BEEF, 32'(4 + CNT_B), 1'b0};
        vecs[11] = '{1'b1, 3'b000, 32'h41,   32'h1111_1111, 3'b000, 32'h40, 32'h0000_0000, 32'(4 + CNT_B), 1'b1};

        // reset state
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 32'h0);
        #1;
        checkOutput("reset_rd",    RD,                 32'h0);
        checkOutput("reset_count", WriteCount,         32'h0);
        checkOutput("reset_err",   {31'h0, AlignErr},  32'h0);

        // directed table
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, vecs[i].we, vecs[i].stType, vecs[i].stAddr, vecs[i].stData,
                          32'h0040_0000 + 32'(4 * i));
            applyStimulus(1'b0, 1'b0, vecs[i].ldType, vecs[i].ldAddr, 32'h0, 32'h0);
            #1;
            checkOutput($sformatf("vec%0d_rd", i),    RD,                vecs[i].expRd);
            checkOutput($sformatf("vec%0d_count", i), WriteCount,        vecs[i].expCount);
            checkOutput($sformatf("vec%0d_err", i),   {31'h0, AlignErr}, {31'h0, vecs[i].expErr});
        end

        // sticky alignment flag holds through idle cycles
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 3'b000, 32'h40, 32'h0, 32'h0);
            #1;
            checkOutput($sformatf("sticky%0d_err", i), {31'h0, AlignErr}, 32'h1);
        end
        checkOutput("sticky_count", WriteCount, 32'(4 + CNT_B));

        // same-cycle load sees old data; next cycle sees new
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h10, 32'hCAFE_F00D, 32'h0040_1000);
        #1;
        checkOutput("samecycle_old", RD, 32'h1234_5678);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h10, 32'h0, 32'h0);
        #1;
        checkOutput("nextcycle_new", RD,         32'hCAFE_F00D);
        checkOutput("nextcycle_cnt", WriteCount, 32'(5 + CNT_B));

        // reset has priority over a simultaneous store
        applyStimulus(1'b1, 1'b1, 3'b000, 32'h10, 32'h0000_0055, 32'h0040_2000);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h10, 32'h0, 32'h0);
        #1;
        checkOutput("rststore_rd",    RD,                32'h0);
        checkOutput("rststore_count", WriteCount,        32'h0);
        checkOutput("rststore_err",   {31'h0, AlignErr}, 32'h0);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        #1;
        checkOutput("rststore_word0", RD, 32'h0);

        // first store straight after reset is accepted
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h20, 32'h0BAD_CAFE, 32'h0040_3000);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h20, 32'h0, 32'h0);
        #1;
        checkOutput("postrst_rd",    RD,         32'h0BAD_CAFE);
        checkOutput("postrst_count", WriteCount, 32'h1);

        // misaligned half store: flag set, word untouched
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h21, 32'h0000_1234, 32'h0040_3004);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h20, 32'h0, 32'h0);
        #1;
        checkOutput("halfmis_rd",    RD,                32'h0BAD_CAFE);
        checkOutput("halfmis_count", WriteCount,        32'h1);
        checkOutput("halfmis_err",   {31'h0, AlignErr}, 32'h1);

        // randomized phase against the byte-array model
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic        w;
            logic [2:0]  t;
            logic [31:0] a;
            r = ($urandom_range(0, 39) == 0);
            w = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 7))
                0, 1:    t = 3'b000;
                2, 3:    t = 3'b001;
                4, 5:    t = 3'b010;
                6:       t = 3'b011;
                default: t = 3'b111;
            endcase
            a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 15)) << 12);
            applyStimulus(r, w, t, a, $urandom, $urandom);
            #1;
            checkOutput($sformatf("rand%0d_rd", i),    RD,                modelLoad(t, a));
            checkOutput($sformatf("rand%0d_count", i), WriteCount,        mCount);
            checkOutput($sformatf("rand%0d_err", i),   {31'h0, AlignErr}, {31'h0, mErr});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
